line_buffer_3row: RTL and testbench
===================================

// Module: line_buffer_3row
// PURPOSE
//  Upstream stage of the 3x3 matrix/Laplacian window. Takes a raster pixel stream, one pixel per
//  valid cycle, and presents three vertically aligned pixels: same column, rows r-2, r-1 and r.
//  These drive the window's din1/din2/din3 inputs under a shared valid strobe.
//  Two on-chip line memories hold the previous two rows.
// PARAMETERS
//  PIC_WIDTH   250  pixels per line (line-memory depth); legal range 3..2047
//  PIC_HEIGHT  250  lines per frame; legal range 3..2047
//  WIDTH       24   pixel width in bits (RGB888 or replicated grey)
//  CNT_W       11   width of the column and row counters; must hold PIC_WIDTH-1 and PIC_HEIGHT-1
// PORTS
//  clk        in   1      system clock; all logic on the rising edge
//  rst_n      in   1      synchronous active-low reset
//  sof        in   1      start of frame; qualifies the first pixel of a frame (sampled with valid_in)
//  valid_in   in   1      din holds a pixel this cycle
//  din        in   WIDTH  input pixel
//  valid_out  out  1      dout1..3 valid; connects to the window's valid_in
//  dout1      out  WIDTH  pixel from row r-2 (top)
//  dout2      out  WIDTH  pixel from row r-1 (middle)
//  dout3      out  WIDTH  pixel from row r (current, bottom)
//  busy       out  1      high from the first accepted pixel to the last pixel of the frame
// BEHAVIOUR
//  - Reset (rst_n low at a clk edge):
//      all outputs go to 0; col=0, row=0; state=FILL0.
//      Line-memory contents are don't-care and are not cleared.
//  - col counts 0..PIC_WIDTH-1 on each valid_in. It wraps to 0 and increments row.
//  - row wraps to 0 after PIC_HEIGHT-1. The frame-end wrap returns state to FILL0 and drops busy.
//  - With valid_in low, counters, memories and outputs hold; valid_out=0.
//    No gaps are inserted and none are removed.
//  - sof=1 with valid_in=1: the pixel is taken as col=0, row=0 and state forced to FILL0.
//    This applies even mid-frame (resync); the partial frame is abandoned.
//    sof with valid_in=0 is ignored.
//  - Memories: lineA holds row r-1, lineB holds row r-2. On each valid_in at address col:
//      read lineA[col] and lineB[col] (read-before-write);
//      then lineB[col] <= old lineA[col] and lineA[col] <= din.
//  - FSM:
//      FILL0  row 0 being written. No output. Goes to FILL1 at the end of row 0.
//      FILL1  row 1 being written. No output. Goes to STREAM at the end of row 1.
//      STREAM rows 2..PIC_HEIGHT-1. Outputs emitted. Goes to FILL0 after the last pixel of the frame.
//  - Output registers, latency 1 clk:
//      in STREAM, one cycle after an accepted pixel: valid_out=1, dout3=din, dout2=old lineA[col],
//      dout1=old lineB[col].
//      Otherwise valid_out=0 and dout1..3 hold their last value.
//  - Per frame: exactly PIC_WIDTH*(PIC_HEIGHT-2) valid_out pulses (feature off).
//  - Back-to-back frames with no idle cycle are legal.
//  - Reset mid-frame: the next frame must start with sof. No stale output may be emitted.
// CONFIGURATION
//  LINE_BUF_EDGE_REP_EN
//   undefined: behaviour as above; the two top rows emit no output.
//   defined:   top-edge replication; output count = PIC_WIDTH*PIC_HEIGHT.
//     FILL0: valid_out=1 with dout1=dout2=dout3=din.
//     FILL1: valid_out=1 with dout1=dout2=old lineA[col] and dout3=din.
//     STREAM unchanged. Latency stays 1 clk.
// TESTING
//  1. Reset, PIC_WIDTH=4, PIC_HEIGHT=4; pixels = 16*row+col; sof on the first pixel.
//     -> first valid_out 1 clk after pixel (2,0): dout1=0x00, dout2=0x10, dout3=0x20.
//     -> exactly 8 pulses in total; last one dout1=0x13, dout2=0x23, dout3=0x33.
//  2. Same frame with valid_in toggled 1/0 every cycle.
//     -> identical dout sequence; valid_out never high in the cycle after valid_in=0.
//  3. Two frames back-to-back, the second offset by +0x80.
//     -> frame-2 output starts only after its row 2, with dout1=0x80.
//     -> no mixing of frame-1 rows into frame-2 output.
//  4. Mid-frame sof at (2,1).
//     -> valid_out stays low until the new row 2; counters restart at 0.
//  5. rst_n low for 1 clk during row 3, then a fresh frame.
//     -> all outputs 0 after the edge; output pattern as in test 1.
//  6. LINE_BUF_EDGE_REP_EN defined, frame of test 1.
//     -> 16 pulses; first pulse dout1=dout2=dout3=0x00.
//     -> pixel (1,2) gives dout1=dout2=0x02, dout3=0x12.

Source files
------------

// File: rtl/line_buffer_3row.sv
// Three-row line buffer: delivers column-aligned pixels from rows r-2, r-1 and r of a raster stream.
// Optional top-edge replication is enabled by defining LINE_BUF_EDGE_REP_EN.
module line_buffer_3row #(
  parameter int PIC_WIDTH  = 250,
  parameter int PIC_HEIGHT = 250,
  parameter int WIDTH      = 24,
  parameter int CNT_W      = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sof,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] din,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  localparam int AW = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;

  typedef enum logic [1:0] {
    FILL0  = 2'd0,
    FILL1  = 2'd1,
    STREAM = 2'd2
  } state_e;

  state_e           state_q, state_eff, state_d;
  logic [CNT_W-1:0] col_q, row_q;
  logic [CNT_W-1:0] col_eff, row_eff;
  logic [CNT_W-1:0] col_d, row_d;
  logic             busy_q, busy_d;
  logic             restart;
  logic [AW-1:0]    addr;

  logic [WIDTH-1:0] line_a [PIC_WIDTH];
  logic [WIDTH-1:0] line_b [PIC_WIDTH];
  logic [WIDTH-1:0] rd_a, rd_b;

  logic             emit;
  logic [WIDTH-1:0] top_d, mid_d;

  // A sof pixel is treated as position (0,0) of a fresh frame, even mid-frame.
  always_comb begin
    restart   = valid_in & sof;
    col_eff   = restart ? '0 : col_q;
    row_eff   = restart ? '0 : row_q;
    state_eff = restart ? FILL0 : state_q;
    addr      = col_eff[AW-1:0];
    rd_a      = line_a[addr];
    rd_b      = line_b[addr];
  end

  always_comb begin
    col_d   = col_eff + CNT_W'(1);
    row_d   = row_eff;
    state_d = state_eff;
    busy_d  = 1'b1;
    if (col_eff == CNT_W'(PIC_WIDTH - 1)) begin
      col_d = '0;
      if (row_eff == CNT_W'(PIC_HEIGHT - 1)) begin
        row_d   = '0;
        state_d = FILL0;
        busy_d  = 1'b0;
      end else begin
        row_d = row_eff + CNT_W'(1);
        case (state_eff)
          FILL0:   state_d = FILL1;
          default: state_d = STREAM;
        endcase
      end
    end
  end

  always_comb begin
    top_d = rd_b;
    mid_d = rd_a;
`ifdef LINE_BUF_EDGE_REP_EN
    emit = 1'b1;
    case (state_eff)
      FILL0: begin
        top_d = din;
        mid_d = din;
      end
      FILL1: begin
        top_d = rd_a;
        mid_d = rd_a;
      end
      default: begin
        top_d = rd_b;
        mid_d = rd_a;
      end
    endcase
`else
    emit = (state_eff == STREAM);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FILL0;
      col_q     <= '0;
      row_q     <= '0;
      busy_q    <= 1'b0;
      valid_out <= 1'b0;
      dout1     <= '0;
      dout2     <= '0;
      dout3     <= '0;
    end else begin
      valid_out <= valid_in & emit;
      if (valid_in) begin
        state_q <= state_d;
        col_q   <= col_d;
        row_q   <= row_d;
        busy_q  <= busy_d;
        if (emit) begin
          dout1 <= top_d;
          dout2 <= mid_d;
          dout3 <= din;
        end
      end
    end
  end

  // Read-before-write: the old lineA word shifts into lineB as the new pixel lands in lineA.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      line_b[addr] <= rd_a;
      line_a[addr] <= din;
    end
  end

  assign busy      = busy_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Bench for line_buffer_3row: image-array reference model, queue scoreboard, directed and random frames.
// Honours LINE_BUF_EDGE_REP_EN the same way as the design.
module tb_line_buffer_3row;
  localparam int PW = 4;
  localparam int PH = 4;
  localparam int W  = 24;
`ifdef LINE_BUF_EDGE_REP_EN
  localparam int PULSES = PW * PH;
`else
  localparam int PULSES = PW * (PH - 2);
`endif

  logic         clk = 1'b0;
  logic         rst_n, sof, valid_in;
  logic [W-1:0] din;
  logic         valid_out, busy;
  logic [W-1:0] dout1, dout2, dout3;
  logic [1:0]   fsm_state;

  line_buffer_3row #(
    .PIC_WIDTH (PW),
    .PIC_HEIGHT(PH),
    .WIDTH     (W),
    .CNT_W     (11)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sof      (sof),
    .valid_in (valid_in),
    .din      (din),
    .valid_out(valid_out),
    .dout1    (dout1),
    .dout2    (dout2),
    .dout3    (dout3),
    .busy     (busy),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3*W-1:0] exp_q[$];
  logic [3*W-1:0] obs_q[$];
  logic [3*W-1:0] o, e, e_last;

  logic [W-1:0] img [PH][PW];
  int           m_r, m_c;
  bit           m_busy;

  int   gap_viol = 0;
  logic last_vin = 1'b0;

  always @(posedge clk) last_vin <= valid_in;

  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      obs_q.push_back({dout1, dout2, dout3});
      if (last_vin !== 1'b1) gap_viol++;
    end
  end

  // Reference model: keeps the whole frame as a picture and looks up rows above.
  task automatic model_reset();
    m_r = 0;
    m_c = 0;
    m_busy = 0;
  endtask

  task automatic model_accept(input bit s, input logic [W-1:0] p);
    if (s) begin
      m_r = 0;
      m_c = 0;
    end
    img[m_r][m_c] = p;
    if (m_r >= 2) exp_q.push_back({img[m_r-2][m_c], img[m_r-1][m_c], p});
`ifdef LINE_BUF_EDGE_REP_EN
    else if (m_r == 0) exp_q.push_back({p, p, p});
    else exp_q.push_back({img[0][m_c], img[0][m_c], p});
`endif
    m_busy = 1;
    m_c++;
    if (m_c == PW) begin
      m_c = 0;
      m_r++;
      if (m_r == PH) begin
        m_r = 0;
        m_busy = 0;
      end
    end
  endtask

  task automatic drive(input bit s, input bit v, input logic [W-1:0] p);
    sof      = s;
    valid_in = v;
    din      = p;
    @(posedge clk);
    #1;
    if (v) model_accept(s, p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(bit'($urandom_range(0, 1)), 1'b0, W'($urandom));
  endtask

  // gap_mode: 0 contiguous, 1 idle after every pixel, 2 random idles. rnd selects random pixels.
  task automatic send_frame(input logic [W-1:0] off, input int gap_mode, input bit rnd);
    logic [W-1:0] pix;
    for (int r = 0; r < PH; r++) begin
      for (int c = 0; c < PW; c++) begin
        pix = rnd ? W'($urandom) : W'(16 * r + c) + off;
        drive(r == 0 && c == 0, 1'b1, pix);
        if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) idle(1);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid_out); end
    checks++;
    if ({dout1, dout2, dout3} !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", {dout1, dout2, dout3}); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    rst_n = 1'b1;
    model_reset();
    idle(2);
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL reset_idle_out got %0d want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b1, W'(0));
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start got %0b want 1", busy); end
    for (int i = 1; i < PW * PH; i++) drive(1'b0, 1'b1, W'(16 * (i / PW) + (i % PW)));
    idle(2);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %0b want 0", busy); end
    checks++;
    if (obs_q.size() != PULSES) begin errors++; $display("FAIL basic_count got %0d want %0d", obs_q.size(), PULSES); end
`ifdef LINE_BUF_EDGE_REP_EN
    checks++;
    if (obs_q[0] !== 72'h000000_000000_000000) begin errors++; $display("FAIL basic_first got %h want 0", obs_q[0]); end
    checks++;
    if (obs_q[6] !== 72'h000002_000002_000012) begin errors++; $display("FAIL basic_px12 got %h want 000002000002000012", obs_q[6]); end
`else
    checks++;
    if (obs_q[0] !== 72'h000000_000010_000020) begin errors++; $display("FAIL basic_first got %h want 000000000010000020", obs_q[0]); end
`endif
    checks++;
    if (obs_q[PULSES-1] !== 72'h000013_000023_000033) begin errors++; $display("FAIL basic_last got %h want 000013000023000033", obs_q[PULSES-1]); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL basic_px got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_gaps();
    gap_viol = 0;
    send_frame(W'(0), 1, 1'b0);
    idle(2);
    e_last = exp_q[$];
    checks++;
    if (gap_viol != 0) begin errors++; $display("FAIL gaps_valid_after_idle got %0d want 0", gap_viol); end
    checks++;
    if ({dout1, dout2, dout3} !== e_last) begin errors++; $display("FAIL gaps_hold got %h want %h", {dout1, dout2, dout3}, e_last); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL gaps_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL gaps_px got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    send_frame(W'(0), 0, 1'b0);
    send_frame(W'(8'h80), 0, 1'b0);
    idle(2);
    checks++;
    if (obs_q.size() != 2 * PULSES) begin errors++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), 2 * PULSES); end
    checks++;
    if (obs_q[PULSES][3*W-1:2*W] !== W'(8'h80)) begin errors++; $display("FAIL b2b_f2_top got %h want 80", obs_q[PULSES][3*W-1:2*W]); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL b2b_px got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_resync();
    for (int i = 0; i < 2 * PW + 1; i++) drive(1'b0, 1'b1, W'(16 * (i / PW) + (i % PW)));
    send_frame(W'(8'h40), 0, 1'b0);
    idle(2);
    checks++;
    if (obs_q.size() != PULSES + 1 + ((PULSES == PW * PH) ? 2 * PW : 0)) begin
      errors++; $display("FAIL resync_count got %0d want %0d", obs_q.size(), PULSES + 1 + ((PULSES == PW * PH) ? 2 * PW : 0));
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL resync_busy got %0b want 0", busy); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL resync_px got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3 * PW + 2; i++) drive(i == 0, 1'b1, W'(16 * (i / PW) + (i % PW)) + W'(8'h55));
    checks++;
    if (busy !== bit'(m_busy)) begin errors++; $display("FAIL rstmid_busy_before got %0b want %0b", busy, m_busy); end
    rst_n = 1'b0;
    drive(1'b0, 1'b0, W'($urandom));
    rst_n = 1'b1;
    model_reset();
    checks++;
    if ({valid_out, busy, dout1, dout2, dout3} !== '0) begin
      errors++; $display("FAIL rstmid_zero got %h want 0", {valid_out, busy, dout1, dout2, dout3});
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL rstmid_pre_px got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
    send_frame(W'(0), 0, 1'b0);
    idle(2);
    checks++;
    if (obs_q.size() != PULSES) begin errors++; $display("FAIL rstmid_count got %0d want %0d", obs_q.size(), PULSES); end
`ifdef LINE_BUF_EDGE_REP_EN
    checks++;
    if (obs_q[0] !== 72'h0) begin errors++; $display("FAIL rstmid_first got %h want 0", obs_q[0]); end
`else
    checks++;
    if (obs_q[0] !== 72'h000000_000010_000020) begin errors++; $display("FAIL rstmid_first got %h want 000000000010000020", obs_q[0]); end
`endif
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL rstmid_px got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    gap_viol = 0;
    for (int f = 0; f < 4; f++) send_frame(W'(0), 2, 1'b1);
    idle(2);
    checks++;
    if (gap_viol != 0) begin errors++; $display("FAIL rand_valid_after_idle got %0d want 0", gap_viol); end
    checks++;
    if (obs_q.size() != 4 * PULSES) begin errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), 4 * PULSES); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL rand_px got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    rst_n    = 1'b0;
    sof      = 1'b0;
    valid_in = 1'b0;
    din      = '0;
    model_reset();
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_resync();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
